// File: rtl/lsu_split_if.sv
// Bundle of LSU request/response handshake and data-memory bus signals.
// The slave modport is the LSU side; master is the requester/memory side.
interface lsu_split_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [3:0]        i_size;
  logic              i_signed;
  logic              i_is_store;
  logic [31:0]       i_wr_data;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rd_data;
  logic              o_err;
  logic [ADDR_W-3:0] o_addr_to_dmem;
  logic [31:0]       o_wr_data_to_dmem;
  logic [31:0]       i_rd_data_from_dmem;
  logic [3:0]        o_mask_to_dmem;
  logic              o_mem_we;

  modport slave (
    input  i_req_valid, i_addr, i_size, i_signed, i_is_store, i_wr_data, i_rsp_ready,
           i_rd_data_from_dmem,
    output o_req_ready, o_rsp_valid, o_rd_data, o_err, o_addr_to_dmem, o_wr_data_to_dmem,
           o_mask_to_dmem, o_mem_we
  );

  modport master (
    output i_req_valid, i_addr, i_size, i_signed, i_is_store, i_wr_data, i_rsp_ready,
           i_rd_data_from_dmem,
    input  o_req_ready, o_rsp_valid, o_rd_data, o_err, o_addr_to_dmem, o_wr_data_to_dmem,
           o_mask_to_dmem, o_mem_we
  );
endinterface

// File: rtl/lsu_split.sv
// Load/store unit that splits word-crossing accesses into two word beats, merges and
// extends load data, and answers every request with one response.
module lsu_split #(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  lsu_split_if.slave io_bus
);
  typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StWait, StResp} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_size;
  logic              r_signed, r_store, r_err;
  logic [31:0]       r_wdata, r_word0, r_rd_data;

  logic              w_accept, w_done, w_req_err, w_split;
  logic [1:0]        w_off;
  logic [3:0]        w_base;
  logic [7:0]        w_m8;
  logic [63:0]       w_wsh;
  logic [31:0]       w_w0, w_w1, w_rsh, w_load;
  logic [ADDR_W-3:0] w_waddr;

  assign w_accept = (r_state == StIdle) && io_bus.i_req_valid;
  assign w_done   = (r_state == StResp) && io_bus.i_rsp_ready;
  assign w_off    = r_addr[1:0];
  assign w_waddr  = r_addr[ADDR_W-1:2];
  assign w_m8     = {4'b0000, w_base} << w_off;
  assign w_split  = (w_m8[7:4] != 4'b0000);
  assign w_wsh    = {32'h0, r_wdata} << {w_off, 3'b000};

  // For a single beat the word is still on the memory bus during WAIT.
  assign w_w0  = w_split ? r_word0 : io_bus.i_rd_data_from_dmem;
  assign w_w1  = w_split ? io_bus.i_rd_data_from_dmem : 32'h0;
  assign w_rsh = 32'({w_w1, w_w0} >> {w_off, 3'b000});

  always_comb begin
    w_base = 4'b0000;
    case (r_size)
      4'd1:    w_base = 4'b0001;
      4'd2:    w_base = 4'b0011;
      4'd4:    w_base = 4'b1111;
      default: w_base = 4'b0000;
    endcase
  end

  always_comb begin
    w_req_err = 1'b0;
    case (io_bus.i_size)
      4'd1:    w_req_err = 1'b0;
      4'd2:    w_req_err = !MISALIGN_EN && io_bus.i_addr[0];
      4'd4:    w_req_err = !MISALIGN_EN && (io_bus.i_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_load = w_rsh;
    case (r_size)
      4'd1:    w_load = {{24{r_signed & w_rsh[7]}}, w_rsh[7:0]};
      4'd2:    w_load = {{16{r_signed & w_rsh[15]}}, w_rsh[15:0]};
      default: w_load = w_rsh;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (io_bus.i_req_valid) w_state_nxt = w_req_err ? StResp : StAcc0;
      StAcc0: w_state_nxt = w_split ? StAcc1 : StWait;
      StAcc1: w_state_nxt = StWait;
      StWait: w_state_nxt = StResp;
      StResp: if (io_bus.i_rsp_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    io_bus.o_req_ready       = (r_state == StIdle);
    io_bus.o_rsp_valid       = (r_state == StResp);
    io_bus.o_addr_to_dmem    = '0;
    io_bus.o_mask_to_dmem    = 4'b0000;
    io_bus.o_wr_data_to_dmem = 32'h0;
    io_bus.o_mem_we          = 1'b0;
    case (r_state)
      StAcc0: begin
        io_bus.o_addr_to_dmem    = w_waddr;
        io_bus.o_mask_to_dmem    = w_m8[3:0];
        io_bus.o_wr_data_to_dmem = w_wsh[31:0];
        io_bus.o_mem_we          = r_store;
      end
      StAcc1: begin
        io_bus.o_addr_to_dmem    = w_waddr + (ADDR_W-2)'(1);
        io_bus.o_mask_to_dmem    = w_m8[7:4];
        io_bus.o_wr_data_to_dmem = w_wsh[63:32];
        io_bus.o_mem_we          = r_store;
      end
      default: ;
    endcase
  end

  assign io_bus.o_rd_data = r_rd_data;
  assign io_bus.o_err     = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr    <= '0;
      r_size    <= 4'd0;
      r_signed  <= 1'b0;
      r_store   <= 1'b0;
      r_wdata   <= 32'h0;
      r_word0   <= 32'h0;
      r_rd_data <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= io_bus.i_addr;
        r_size    <= io_bus.i_size;
        r_signed  <= io_bus.i_signed;
        r_store   <= io_bus.i_is_store;
        r_wdata   <= io_bus.i_wr_data;
        r_err     <= w_req_err;
        r_rd_data <= 32'h0;
      end
      if (r_state == StAcc1) r_word0 <= io_bus.i_rd_data_from_dmem;
      if (r_state == StWait) r_rd_data <= r_store ? 32'h0 : w_load;
      if (w_done) begin
        r_err     <= 1'b0;
        r_rd_data <= 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: one instance with split support and one that rejects
// misaligned accesses, with a small word memory behind the first.
module tb_lsu_split;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_split_if #(.ADDR_W(32)) b1 ();
  lsu_split_if #(.ADDR_W(32)) b2 ();

  lsu_split #(.ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(b1.slave));
  lsu_split #(.ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut2 (.i_clk(clk), .i_rst(rst), .io_bus(b2.slave));

  logic        v1 = 1'b0, v2 = 1'b0, rsp_rdy = 1'b0, sgn = 1'b0, st = 1'b0, sel = 1'b0;
  logic [31:0] addr = 32'h0, wd = 32'h0, rd1 = 32'h0;
  logic [3:0]  size = 4'd0;
  logic [31:0] mem [0:255];
  logic [7:0]  a_lat = 8'h0;

  assign b1.i_req_valid = v1;
  assign b1.i_addr = addr;
  assign b1.i_size = size;
  assign b1.i_signed = sgn;
  assign b1.i_is_store = st;
  assign b1.i_wr_data = wd;
  assign b1.i_rsp_ready = rsp_rdy;
  assign b1.i_rd_data_from_dmem = rd1;
  assign b2.i_req_valid = v2;
  assign b2.i_addr = addr;
  assign b2.i_size = size;
  assign b2.i_signed = sgn;
  assign b2.i_is_store = st;
  assign b2.i_wr_data = wd;
  assign b2.i_rsp_ready = rsp_rdy;
  assign b2.i_rd_data_from_dmem = 32'h0;

  logic        w_req_ready, w_rsp_valid, w_err;
  logic [31:0] w_rd_data;
  assign w_req_ready = sel ? b2.o_req_ready : b1.o_req_ready;
  assign w_rsp_valid = sel ? b2.o_rsp_valid : b1.o_rsp_valid;
  assign w_err       = sel ? b2.o_err : b1.o_err;
  assign w_rd_data   = sel ? b2.o_rd_data : b1.o_rd_data;

  // Memory answers the cycle after the address is driven.
  always @(negedge clk) a_lat <= b1.o_addr_to_dmem[7:0];
  always @(posedge clk) rd1 <= mem[a_lat];

  int          nb1 = 0, nb2 = 0;
  logic [29:0] ba [0:63];
  logic [3:0]  bm [0:63];
  logic [31:0] bd [0:63];
  logic        bw [0:63];
  always @(negedge clk) begin
    if (b1.o_mask_to_dmem != 4'h0 && nb1 < 64) begin
      ba[nb1] <= b1.o_addr_to_dmem;
      bm[nb1] <= b1.o_mask_to_dmem;
      bd[nb1] <= b1.o_wr_data_to_dmem;
      bw[nb1] <= b1.o_mem_we;
      nb1     <= nb1 + 1;
    end
    if (b2.o_mask_to_dmem != 4'h0) nb2 <= nb2 + 1;
  end

  int n_tests = 0, n_fail = 0;
  int b_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [29:0] ea,
                            input logic [3:0] em, input logic [31:0] ed, input logic ew);
    check({tag, " addr"}, 32'(ba[idx]), 32'(ea));
    check({tag, " mask"}, 32'(bm[idx]), 32'(em));
    check({tag, " data"}, bd[idx], ed);
    check({tag, " we"}, 32'(bw[idx]), 32'(ew));
  endtask

  task automatic run_req(input string tag, input logic s, input logic [31:0] a,
                         input logic [3:0] sz, input logic sg, input logic stv,
                         input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                         input int exp_lat, input int hold);
    int k;
    @(negedge clk);
    sel = s; addr = a; size = sz; sgn = sg; st = stv; wd = d;
    b_start = nb1;
    if (s) v2 = 1'b1;
    else v1 = 1'b1;
    #1 check({tag, " ready"}, 32'(w_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0;
    k = 1;
    while (!w_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    check({tag, " rd_data"}, w_rd_data, exp_d);
    check({tag, " err"}, 32'(w_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(w_rsp_valid), 32'd1);
      check({tag, " hold ready"}, 32'(w_req_ready), 32'd0);
      check({tag, " hold err"}, 32'(w_err), 32'(exp_e));
      check({tag, " hold data"}, w_rd_data, exp_d);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_rdy = 1'b0;
    check({tag, " released"}, 32'(w_rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " req_ready"}, 32'(b1.o_req_ready), 32'd1);
    check({tag, " rsp_valid"}, 32'(b1.o_rsp_valid), 32'd0);
    check({tag, " err"}, 32'(b1.o_err), 32'd0);
    check({tag, " we"}, 32'(b1.o_mem_we), 32'd0);
    check({tag, " mask"}, 32'(b1.o_mask_to_dmem), 32'd0);
    check({tag, " addr"}, 32'(b1.o_addr_to_dmem), 32'd0);
    check({tag, " wdata"}, b1.o_wr_data_to_dmem, 32'd0);
    check({tag, " rd_data"}, b1.o_rd_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h80] = 32'h80FF0000;
    mem[8'hFF] = 32'hBBAA9988;
    mem[8'h00] = 32'h44332211;

    @(negedge clk);
    check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_req("ld4 aligned", 1'b0, 32'h100, 4'd4, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    check("ld4 aligned beats", 32'(nb1 - b_start), 32'd1);
    check_beat("ld4 aligned b0", b_start, 30'h40, 4'b1111, 32'h0, 1'b0);

    run_req("ld1 signed", 1'b0, 32'h203, 4'd1, 1'b1, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
    check("ld1 signed mask", 32'(bm[b_start]), 32'h8);
    run_req("ld1 unsigned", 1'b0, 32'h203, 4'd1, 1'b0, 1'b0, 32'h0, 32'h00000080, 1'b0, 3, 0);
    run_req("ld2 signed", 1'b0, 32'h202, 4'd2, 1'b1, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);

    mem[8'h40] = 32'h33221100;
    mem[8'h41] = 32'h77665544;
    run_req("ld4 split", 1'b0, 32'h102, 4'd4, 1'b0, 1'b0, 32'h0, 32'h55443322, 1'b0, 4, 0);
    check("ld4 split beats", 32'(nb1 - b_start), 32'd2);
    check_beat("ld4 split b0", b_start, 30'h40, 4'b1100, 32'h0, 1'b0);
    check_beat("ld4 split b1", b_start + 1, 30'h41, 4'b0011, 32'h0, 1'b0);

    run_req("st2 split", 1'b0, 32'h7, 4'd2, 1'b0, 1'b1, 32'h0000ABCD, 32'h0, 1'b0, 4, 0);
    check("st2 split beats", 32'(nb1 - b_start), 32'd2);
    check_beat("st2 split b0", b_start, 30'h1, 4'b1000, 32'hCD000000, 1'b1);
    check_beat("st2 split b1", b_start + 1, 30'h2, 4'b0001, 32'h000000AB, 1'b1);

    run_req("ld4 wrap", 1'b0, 32'hFFFFFFFE, 4'd4, 1'b0, 1'b0, 32'h0, 32'h2211BBAA, 1'b0, 4, 0);
    check_beat("ld4 wrap b0", b_start, 30'h3FFFFFFF, 4'b1100, 32'h0, 1'b0);
    check_beat("ld4 wrap b1", b_start + 1, 30'h0, 4'b0011, 32'h0, 1'b0);

    run_req("size3 en", 1'b0, 32'h100, 4'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    check("size3 en beats", 32'(nb1 - b_start), 32'd0);

    run_req("noalign ld4", 1'b1, 32'h102, 4'd4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1, 5);
    run_req("noalign size3", 1'b1, 32'h100, 4'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
    check("noalign beats", 32'(nb2), 32'd0);

    // Reset while the second beat of a split store is on the bus.
    @(negedge clk);
    sel = 1'b0; addr = 32'h7; size = 4'd2; sgn = 1'b0; st = 1'b1; wd = 32'h0000ABCD;
    b_start = nb1;
    v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    #1 check("rst acc1 mask", 32'(b1.o_mask_to_dmem), 32'h1);
    rst = 1'b1;
    #1 check_reset_outs("rst mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst mid beats", 32'(nb1 - b_start), 32'd2);
    check("rst mid idle", 32'(b1.o_req_ready), 32'd1);

    run_req("post rst ld4", 1'b0, 32'h100, 4'd4, 1'b0, 1'b0, 32'h0, 32'h33221100, 1'b0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width; memory word address is ADDR_W-2 bits.
REQ-002 Parameter MISALIGN_EN, default 1; 1 = misaligned accesses split into two word beats, 0 = misaligned accesses rejected with error.
REQ-003 i_clk  input  1  single clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  input  1  request present.
REQ-006 o_req_ready  output  1  block can accept a request.
REQ-007 i_addr  input  ADDR_W  byte address.
REQ-008 i_size  input  4  access size in bytes (1, 2, 4).
REQ-009 i_signed  input  1  sign-extend load result (0 = zero-extend).
REQ-010 i_is_store  input  1  1 = store, 0 = load.
REQ-011 i_wr_data  input  32  store data, right-aligned.
REQ-012 o_rsp_valid  output  1  response present.
REQ-013 i_rsp_ready  input  1  consumer takes response.
REQ-014 o_rd_data  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 o_err  output  1  request rejected; no memory access made.
REQ-016 o_addr_to_dmem  output  ADDR_W-2  word address to data memory.
REQ-017 o_wr_data_to_dmem  output  32  lane-aligned store data.
REQ-018 i_rd_data_from_dmem  input  32  read data, valid the cycle after the address is driven.
REQ-019 o_mask_to_dmem  output  4  byte-lane enables.
REQ-020 o_mem_we  output  1  write strobe.

Function
REQ-021 FSM states: IDLE, ACC0, ACC1, WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-022 IDLE: i_req_valid=1 captures addr, size, signed, is_store and wr_data; next state ACC0, RESP on error.
REQ-023 off = addr[1:0]; base mask = 0001/0011/1111 for size 1/2/4; lane mask M8 = base << off (8 bits).
REQ-024 Split = M8[7:4] != 0.
REQ-025 Error when size is not 1, 2 or 4, or when MISALIGN_EN=0 and addr is not a multiple of size.
REQ-026 ACC0 drives word address addr[ADDR_W-1:2], mask M8[3:0], and data ({32'b0,wr_data} << 8*off)[31:0]; next state ACC1 if split, else WAIT.
REQ-027 ACC1 drives word address + 1 (wraps modulo 2^(ADDR_W-2)), mask M8[7:4], and data bits [63:32] of the same shift; next state WAIT.
REQ-028 o_mem_we = is_store in ACC0/ACC1 only; otherwise 0; mask and address are don't-care-free, 0 outside ACC states.
REQ-029 Capture of read data: the cycle after ACC0 stores word0; WAIT after ACC1 stores word1.
REQ-030 WAIT computes {word1,word0} >> 8*off, keeps size bytes and extends per i_signed; the result is registered into o_rd_data; next state RESP.
REQ-031 RESP: o_rsp_valid=1, o_rd_data and o_err held stable until i_rsp_ready=1, then IDLE.
REQ-032 Latency from accept cycle to first o_rsp_valid: 3 cycles aligned, 4 split, 1 error.
REQ-033 No new request is accepted before the response handshake completes (one outstanding).
REQ-034 Stores return o_rd_data=0, o_err=0.

Reset
REQ-035 i_rst=1 forces IDLE immediately; o_req_ready=1; o_rsp_valid, o_err, o_mem_we, o_mask_to_dmem, o_addr_to_dmem, o_wr_data_to_dmem and o_rd_data are all 0.
REQ-036 Reset mid-ACC aborts the access; no further beat is issued after deassertion.

Verification
REQ-037 Load, size 4, addr 0x100, mem[0x40]=0xDEADBEEF -> one beat, word address 0x40, mask 1111, we=0; response 0xDEADBEEF 3 cycles after accept.
REQ-038 Signed load, size 1, addr 0x203, mem[0x80]=0x80FF0000 -> mask 1000; response 0xFFFFFF80; same request with i_signed=0 -> 0x00000080.
REQ-039 Load, size 4, addr 0x102, mem[0x40]=0x33221100, mem[0x41]=0x77665544 -> beats at 0x40 with mask 1100 and at 0x41 with mask 0011; response 0x55443322 4 cycles after accept.
REQ-040 Store, size 2, addr 0x7, data 0x0000ABCD -> beat 0x1 with mask 1000 and data 0xCD000000, then beat 0x2 with mask 0001 and data 0x000000AB; we=1 on both beats; response o_rd_data=0, o_err=0.
REQ-041 MISALIGN_EN=0, size 4, addr 0x102 or size 3 -> no memory beats; o_err=1 the cycle after accept; with i_rsp_ready held 0 for 5 cycles the response is held stable and o_req_ready stays 0.
REQ-042 i_rst asserted during ACC1 of a split store -> all outputs at reset values the same cycle; the next request after reset completes normally.
